// File: rtl/sargantana_icache_pkg.sv
// Shared types for the instruction-cache tag controller: default geometry,
// controller state encoding and the tag / set-index / way-mask typedefs.
package sargantana_icache_pkg;

  localparam int ITAG_N_WAY  = 4;
  localparam int ITAG_DEPTH  = 64;
  localparam int ITAG_ADDR_W = $clog2(ITAG_DEPTH);
  localparam int ITAG_TAG_W  = 20;

  typedef enum logic [1:0] {
    INIT_WALK,
    IDLE,
    FLUSH_WALK
  } itag_ctrl_state_t;

  typedef logic [ITAG_TAG_W-1:0]  tag_t;
  typedef logic [ITAG_ADDR_W-1:0] set_idx_t;
  typedef logic [ITAG_N_WAY-1:0]  way_mask_t;

endpackage

// File: rtl/sargantana_itag_cmp.sv
// N-way tag compare against the registered lookup tag; reports only the
// lowest-index matching valid way as a one-hot mask.
module sargantana_itag_cmp #(
  parameter int N_WAY = 4,
  parameter int TAG_W = 20
) (
  input  logic [N_WAY*TAG_W-1:0] tag_way_i,
  input  logic [N_WAY-1:0]       vbit_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic [N_WAY-1:0]       way_o,
  output logic                   hit_o
);

  logic found;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    way_o = '0;
    found = 1'b0;
    for (int w = 0; w < N_WAY; w++) begin
      if (!found && vbit_i[w] && (tag_way_i[w*TAG_W +: TAG_W] == tag_i)) begin
        way_o[w] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign hit_o = found;

endmodule

// File: rtl/sargantana_itag_ctrl.sv
// Arbiter/sequencer for the single-port I-cache tag array: set-walking
// invalidation, refill writes with round-robin victim, and 1-cycle lookups.
module sargantana_itag_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY   = ITAG_N_WAY,
  parameter int TAG_DEPTH      = ITAG_DEPTH,
  parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
  parameter int TAG_WIDHT      = ITAG_TAG_W
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  output logic                                flush_done_o,
  output logic                                busy_o,
  input  logic                                lkp_valid_i,
  output logic                                lkp_ready_o,
  input  logic [TAG_ADDR_WIDHT-1:0]           lkp_addr_i,
  input  logic [TAG_WIDHT-1:0]                lkp_tag_i,
  output logic                                rsp_valid_o,
  output logic                                rsp_hit_o,
  output logic [ICACHE_N_WAY-1:0]             rsp_way_o,
  input  logic                                rfl_valid_i,
  output logic                                rfl_ready_o,
  input  logic [TAG_ADDR_WIDHT-1:0]           rfl_addr_i,
  input  logic [TAG_WIDHT-1:0]                rfl_tag_i,
  output logic [ICACHE_N_WAY-1:0]             rfl_way_o,
  output logic [ICACHE_N_WAY-1:0]             mem_req_o,
  output logic                                mem_we_o,
  output logic                                mem_vbit_o,
  output logic [TAG_WIDHT-1:0]                mem_data_o,
  output logic [TAG_ADDR_WIDHT-1:0]           mem_addr_o,
  input  logic [ICACHE_N_WAY*TAG_WIDHT-1:0]   mem_tag_way_i,
  input  logic [ICACHE_N_WAY-1:0]             mem_vbit_i
);

  localparam int VIC_W = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;
  localparam logic [TAG_ADDR_WIDHT-1:0] LAST_SET = TAG_ADDR_WIDHT'(TAG_DEPTH - 1);
  localparam logic [VIC_W-1:0]          LAST_WAY = VIC_W'(ICACHE_N_WAY - 1);

  itag_ctrl_state_t          state_q, state_d;
  logic [TAG_ADDR_WIDHT-1:0] cnt_q, cnt_d;
  logic [VIC_W-1:0]          victim_q, victim_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      flush_done_q, flush_done_d;
  logic [TAG_WIDHT-1:0]      cmp_tag_q, cmp_tag_d;
  logic [ICACHE_N_WAY-1:0]   cmp_way;
  logic                      cmp_hit;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    victim_d     = victim_q;
    rsp_valid_d  = 1'b0;
    flush_done_d = 1'b0;
    cmp_tag_d    = cmp_tag_q;
    lkp_ready_o  = 1'b0;
    rfl_ready_o  = 1'b0;
    rfl_way_o    = '0;
    mem_req_o    = '0;
    mem_we_o     = 1'b0;
    mem_vbit_o   = 1'b0;
    mem_data_o   = '0;
    mem_addr_o   = '0;
    busy_o       = 1'b0;

    case (state_q)
      INIT_WALK, FLUSH_WALK: begin
        busy_o     = 1'b1;
        mem_req_o  = '1;
        mem_we_o   = 1'b1;
        mem_addr_o = cnt_q;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) begin
          cnt_d        = '0;
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH_WALK;
        end else begin
          // Readies depend only on higher-priority valids, never on their own.
          rfl_ready_o = 1'b1;
          lkp_ready_o = !rfl_valid_i;
          if (rfl_valid_i) begin
            rfl_way_o  = ICACHE_N_WAY'(1) << victim_q;
            mem_req_o  = rfl_way_o;
            mem_we_o   = 1'b1;
            mem_vbit_o = 1'b1;
            mem_data_o = rfl_tag_i;
            mem_addr_o = rfl_addr_i;
            victim_d   = (victim_q == LAST_WAY) ? '0 : victim_q + 1'b1;
          end else if (lkp_valid_i) begin
            mem_req_o   = '1;
            mem_addr_o  = lkp_addr_i;
            cmp_tag_d   = lkp_tag_i;
            rsp_valid_d = 1'b1;
          end
        end
      end
      default: state_d = INIT_WALK;
    endcase

    if (rst_i) begin
      lkp_ready_o = 1'b0;
      rfl_ready_o = 1'b0;
      rfl_way_o   = '0;
      mem_req_o   = '0;
      busy_o      = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst_i) begin
      state_q      <= INIT_WALK;
      cnt_q        <= '0;
      victim_q     <= '0;
      rsp_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      victim_q     <= victim_d;
      rsp_valid_q  <= rsp_valid_d;
      flush_done_q <= flush_done_d;
    end
    // NOTE: the compare tag is pure data qualified by rsp_valid_q, so it needs no reset.
    cmp_tag_q <= cmp_tag_d;
  end

  sargantana_itag_cmp #(
    .N_WAY (ICACHE_N_WAY),
    .TAG_W (TAG_WIDHT)
  ) u_cmp (
    .tag_way_i (mem_tag_way_i),
    .vbit_i    (mem_vbit_i),
    .tag_i     (cmp_tag_q),
    .way_o     (cmp_way),
    .hit_o     (cmp_hit)
  );

  assign flush_done_o = flush_done_q & ~rst_i;
  assign rsp_valid_o  = rsp_valid_q & ~rst_i;
  assign rsp_hit_o    = rsp_valid_o & cmp_hit;
  assign rsp_way_o    = rsp_valid_o ? cmp_way : '0;

endmodule
